multitap_effects: RTL and testbench

- Parametrised successor to the fixed 5-round effects datapath.
- Accepts one ADC sample per handshake and removes the calibration offset.
- Writes the result into an external synchronous ring buffer, then sums NTAPS run-time-configurable delayed taps, each with its own enable and attenuation.
- Saturates the sum and emits a sign-magnitude voltage toward the Pi SPI path.
- Owns its own round sequencing (FSM) instead of relying on an external counter.

---
 rtl/multitap_pkg.sv | 33 +++
 rtl/multitap_effects_if.sv | 24 ++
 rtl/multitap_effects_sm_saturate.sv | 23 ++
 rtl/multitap_effects.sv | 156 +++++++++++++++
 tb/tb_multitap_effects.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multitap_pkg.sv
// Shared types and sign-magnitude helpers for the multi-tap effects datapath.
// Helpers work on 32-bit containers so they serve any W below 31.
package multitap_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    TAP   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  // Two's-complement to sign-magnitude with the sign at bit w and the
  // magnitude clamped to 2^w-1; zero is always encoded positive.
  function automatic logic [31:0] to_sm(input logic signed [31:0] acc,
                                        input int unsigned w);
    logic [31:0] mag;
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    mag = acc[31] ? $unsigned(-acc) : $unsigned(acc);
    if (mag > lim) mag = lim;
    to_sm = mag;
    if (acc[31] && (mag != 32'd0)) to_sm = mag | (32'd1 << w);
  endfunction

  function automatic logic signed [31:0] from_sm(input logic [31:0] sm,
                                                 input int unsigned w);
    logic signed [31:0] mag;
    mag = $signed(sm & ((32'd1 << w) - 32'd1));
    from_sm = (((sm >> w) & 32'd1) != 32'd0) ? -mag : mag;
  endfunction

endpackage

// File: rtl/multitap_effects_if.sv
// Sample/result handshake and external ring-buffer port bundle.
interface multitap_effects_if #(
  parameter int W  = 10,
  parameter int AW = 13
) ();
  logic          sample_valid;
  logic [W-1:0]  sample_voltage;
  logic          out_valid;
  logic [W:0]    out_voltage;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [W:0]    mem_wdata;
  logic [W:0]    mem_rdata;

  modport slave (
    input  sample_valid, sample_voltage, mem_rdata,
    output out_valid, out_voltage, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output sample_valid, sample_voltage, mem_rdata,
    input  out_valid, out_voltage, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/multitap_effects_sm_saturate.sv
// Combinational |acc| clamp to a threshold, emitting W+1-bit sign-magnitude.
module sm_saturate
  import multitap_pkg::*;
#(
  parameter int W    = 10,
  parameter int ACCW = 16
) (
  input  logic signed [ACCW-1:0] acc,
  input  logic        [W-1:0]    threshold,
  output logic        [W:0]      sm
);

  logic [31:0]  full;
  logic [W-1:0] mag;
  logic         unused_hi;

  assign full      = to_sm(32'(acc), W);
  assign mag       = (full[W-1:0] > threshold) ? threshold : full[W-1:0];
  // A clamp to a zero threshold must not leave a negative zero behind.
  assign sm        = {full[W] && (mag != '0), mag};
  assign unused_hi = ^full[31:W+1];

endmodule

// File: rtl/multitap_effects.sv
// Offset-removal, ring-buffer write and NTAPS delayed-tap mix with an
// internal round sequencer; one sample in, one saturated result out.
module multitap_effects
  import multitap_pkg::*;
#(
  parameter int W     = 10,
  parameter int AW    = 13,
  parameter int NTAPS = 4,
  parameter int ACCW  = 16,
  parameter int BIAS  = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  multitap_effects_if.slave     bus,
  input  logic [W-1:0]          offset,
  input  logic [NTAPS-1:0]      tap_en,
  input  logic [NTAPS*AW-1:0]   tap_delay,
  input  logic [NTAPS*3-1:0]    tap_shift,
  input  logic [W-1:0]          sat_threshold,
  output logic                  busy,
  output logic                  overrun
);

  localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          mem_addr_q, mem_addr_d;
  logic                   mem_we_q, mem_we_d;
  logic [W:0]             mem_wdata_q, mem_wdata_d;
  logic                   out_valid_q, out_valid_d;
  logic [W:0]             out_voltage_q, out_voltage_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic signed [ACCW-1:0] acc_q, acc_d;

  logic [KW-1:0]          rd_idx, nxt_idx;
  logic [W-1:0]           rd_mag;
  logic signed [ACCW-1:0] rd_term, acc_tap, acc_new;
  logic [W:0]             wr_sm, out_sm;

  // Read data arriving now belongs to the tap addressed one cycle earlier;
  // in DRAIN the index has stopped advancing, so it already names the last tap.
  assign rd_idx  = (state_q == DRAIN) ? k_q : k_q - KW'(1);
  assign nxt_idx = k_q + KW'(1);
  assign rd_mag  = bus.mem_rdata[W-1:0] >> tap_shift[rd_idx*3 +: 3];
  assign rd_term = ACCW'(from_sm({{(31-W){1'b0}}, bus.mem_rdata[W], rd_mag}, W));
  assign acc_tap = tap_en[rd_idx] ? acc_q + rd_term : acc_q;
  assign acc_new = ACCW'($signed({1'b0, bus.sample_voltage}))
                 - ACCW'($signed({1'b0, offset}))
                 + ACCW'(BIAS);

  sm_saturate #(.W(W), .ACCW(ACCW)) u_wr_sat (
    .acc       (acc_new),
    .threshold ({W{1'b1}}),
    .sm        (wr_sm)
  );

  sm_saturate #(.W(W), .ACCW(ACCW)) u_out_sat (
    .acc       (acc_tap),
    .threshold (sat_threshold),
    .sm        (out_sm)
  );

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    wr_ptr_d      = wr_ptr_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = 1'b0;
    mem_wdata_d   = mem_wdata_q;
    out_valid_d   = 1'b0;
    out_voltage_d = out_voltage_q;
    acc_d         = acc_q;
    overrun_d     = overrun_q | (bus.sample_valid && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (bus.sample_valid) begin
          acc_d       = acc_new;
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q;
          mem_wdata_d = wr_sm;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        k_d        = '0;
        mem_addr_d = wr_ptr_q - tap_delay[0 +: AW];
        state_d    = TAP;
      end
      TAP: begin
        if (k_q != '0) acc_d = acc_tap;
        if (k_q == KW'(NTAPS - 1)) begin
          state_d = DRAIN;
        end else begin
          k_d        = nxt_idx;
          mem_addr_d = wr_ptr_q - tap_delay[nxt_idx*AW +: AW];
        end
      end
      DRAIN: begin
        acc_d         = acc_tap;
        wr_ptr_d      = wr_ptr_q + AW'(1);
        out_valid_d   = 1'b1;
        out_voltage_d = out_sm;
        state_d       = OUT;
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      k_q           <= '0;
      wr_ptr_q      <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      out_valid_q   <= 1'b0;
      out_voltage_q <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      acc_q         <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      wr_ptr_q      <= wr_ptr_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      out_valid_q   <= out_valid_d;
      out_voltage_q <= out_voltage_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      acc_q         <= acc_d;
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_voltage = out_voltage_q;
  assign busy            = busy_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_multitap_effects.sv
// Directed and randomized bench for multitap_effects with a 1-cycle RAM model.
`timescale 1ns/1ps
module tb_multitap_effects;

  localparam int W     = 10;
  localparam int AW    = 13;
  localparam int NTAPS = 4;
  localparam int ACCW  = 16;
  localparam int BIAS  = 15;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multitap_effects_if #(.W(W), .AW(AW)) bus ();

  logic [W-1:0]        offset;
  logic [NTAPS-1:0]    tap_en;
  logic [NTAPS*AW-1:0] tap_delay;
  logic [NTAPS*3-1:0]  tap_shift;
  logic [W-1:0]        sat_threshold;
  logic                busy;
  logic                overrun;

  multitap_effects #(
    .W(W), .AW(AW), .NTAPS(NTAPS), .ACCW(ACCW), .BIAS(BIAS)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus.slave),
    .offset        (offset),
    .tap_en        (tap_en),
    .tap_delay     (tap_delay),
    .tap_shift     (tap_shift),
    .sat_threshold (sat_threshold),
    .busy          (busy),
    .overrun       (overrun)
  );

  // External ring buffer: synchronous write, read data one cycle after address.
  logic [W:0]    ram [DEPTH];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [W:0]    pre_data;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int checks   = 0;
  int failures = 0;

  logic [W:0] mdl [DEPTH];
  int         wp;
  int         d_cfg  [NTAPS];
  int         sh_cfg [NTAPS];
  bit         en_cfg [NTAPS];
  int         off_cfg;
  int         thr_cfg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] sm_model(input int v, input int lim);
    int m;
    m = (v < 0) ? -v : v;
    if (m > lim) m = lim;
    return {((v < 0) && (m != 0)) ? 1'b1 : 1'b0, W'(m)};
  endfunction

  task automatic apply_cfg();
    for (int k = 0; k < NTAPS; k++) begin
      tap_delay[k*AW +: AW] = AW'(d_cfg[k]);
      tap_shift[k*3 +: 3]   = 3'(sh_cfg[k]);
      tap_en[k]             = en_cfg[k];
    end
    offset        = W'(off_cfg);
    sat_threshold = W'(thr_cfg);
  endtask

  task automatic clear_taps();
    for (int k = 0; k < NTAPS; k++) begin
      d_cfg[k] = 0; sh_cfg[k] = 0; en_cfg[k] = 1'b0;
    end
  endtask

  task automatic preload(input int a, input logic [W:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = AW'(a); pre_data = v;
    @(negedge clk);
    pre_we = 1'b0;
    mdl[a] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    wp = 0;
  endtask

  // One full round: the model predicts the write, tap addresses and result
  // from the arithmetic rules, then the DUT is observed cycle by cycle.
  task automatic run_round(input int s, input bit inject, input string tag);
    int         acc, m, a, we_cnt, ov_cnt;
    int         exp_addr [NTAPS];
    logic [W:0] exp_w, exp_o, v;

    acc     = s - off_cfg + BIAS;
    exp_w   = sm_model(acc, (1 << W) - 1);
    mdl[wp] = exp_w;
    for (int k = 0; k < NTAPS; k++) begin
      a = (wp - d_cfg[k] + DEPTH) % DEPTH;
      exp_addr[k] = a;
      if (en_cfg[k]) begin
        v   = mdl[a];
        m   = int'(v[W-1:0]) >> sh_cfg[k];
        acc = v[W] ? acc - m : acc + m;
      end
    end
    exp_o = sm_model(acc, thr_cfg);

    @(negedge clk);
    bus.sample_valid   = 1'b1;
    bus.sample_voltage = W'(s);
    we_cnt = 0;
    ov_cnt = 0;
    for (int c = 1; c <= NTAPS + 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.sample_valid = 1'b0;
        check($sformatf("%s_busy1", tag), busy, 1);
        check($sformatf("%s_we", tag), bus.mem_we, 1);
        check($sformatf("%s_waddr", tag), bus.mem_addr, wp);
        check($sformatf("%s_wdata", tag), bus.mem_wdata, exp_w);
      end else if (c <= NTAPS + 1) begin
        check($sformatf("%s_raddr%0d", tag, c - 2), bus.mem_addr, exp_addr[c-2]);
      end
      if (c == NTAPS + 2) check($sformatf("%s_early_ov", tag), bus.out_valid, 0);
      if (c == NTAPS + 3) begin
        check($sformatf("%s_ovalid", tag), bus.out_valid, 1);
        check($sformatf("%s_out", tag), bus.out_voltage, exp_o);
        check($sformatf("%s_busy_out", tag), busy, 1);
      end
      we_cnt += int'(bus.mem_we);
      ov_cnt += int'(bus.out_valid);
      if (inject && c == 3) begin
        bus.sample_valid   = 1'b1;
        bus.sample_voltage = W'($urandom_range(0, (1 << W) - 1));
      end
      if (inject && c == 4) bus.sample_valid = 1'b0;
    end
    @(negedge clk);
    check($sformatf("%s_idle", tag), busy, 0);
    check($sformatf("%s_hold", tag), bus.out_voltage, exp_o);
    check($sformatf("%s_we_cnt", tag), we_cnt, 1);
    check($sformatf("%s_ov_cnt", tag), ov_cnt, 1);
    wp = (wp + 1) % DEPTH;
  endtask

  initial begin
    int ov;
    reset_n            = 1'b0;
    bus.sample_valid   = 1'b0;
    bus.sample_voltage = '0;
    pre_we             = 1'b0;
    pre_addr           = '0;
    pre_data           = '0;
    clear_taps();
    off_cfg = 0;
    thr_cfg = (1 << W) - 1;
    apply_cfg();
    wp = 0;

    // Clear the buffer while the DUT is held in reset.
    pre_we = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      pre_addr = AW'(i);
      mdl[i]   = '0;
      @(negedge clk);
    end
    pre_we = 1'b0;

    check("rst_out_voltage", bus.out_voltage, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Dry path, negative and zero results.
    off_cfg = 512; apply_cfg();
    run_round(600, 1'b0, "dry");
    check("dry_const", bus.out_voltage, {1'b0, 10'd103});
    run_round(400, 1'b0, "neg");
    check("neg_const", bus.out_voltage, {1'b1, 10'd97});
    run_round(497, 1'b0, "zero");
    check("zero_const", bus.out_voltage, 0);

    // Tap sum across the address wrap.
    do_reset();
    preload(DEPTH - 1, {1'b0, 10'd200});
    preload(DEPTH - 2, {1'b1, 10'd40});
    d_cfg[0] = 1; sh_cfg[0] = 0; en_cfg[0] = 1'b1;
    d_cfg[1] = 2; sh_cfg[1] = 1; en_cfg[1] = 1'b1;
    apply_cfg();
    run_round(507, 1'b0, "wrap");
    check("wrap_const", bus.out_voltage, {1'b0, 10'd190});

    // Saturation on the output path versus the write path.
    clear_taps();
    thr_cfg = 255; off_cfg = 0; apply_cfg();
    run_round(685, 1'b0, "satp");
    check("satp_const", bus.out_voltage, {1'b0, 10'd255});
    off_cfg = 715; apply_cfg();
    run_round(0, 1'b0, "satn");
    check("satn_const", bus.out_voltage, {1'b1, 10'd255});
    off_cfg = 0; apply_cfg();
    run_round(1023, 1'b0, "wclamp");
    check("wclamp_ram", ram[(wp + DEPTH - 1) % DEPTH], {1'b0, 10'd1023});

    // Tap with zero delay sees the sample written this round.
    en_cfg[0] = 1'b1; d_cfg[0] = 0; thr_cfg = 1023; off_cfg = 100; apply_cfg();
    run_round(300, 1'b0, "d0");
    check("d0_const", bus.out_voltage, {1'b0, 10'd430});

    // Reset during the write cycle abandons the round.
    clear_taps(); apply_cfg();
    @(negedge clk);
    bus.sample_valid   = 1'b1;
    bus.sample_voltage = W'(300);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_we", bus.mem_we, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wp = 0;
    ov = 0;
    for (int i = 0; i < NTAPS + 4; i++) begin
      @(negedge clk);
      ov += int'(bus.out_valid);
    end
    check("midrst_no_out", ov, 0);

    // Randomized configurations and samples against the model.
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < NTAPS; k++) begin
        en_cfg[k] = 1'($urandom_range(0, 1));
        d_cfg[k]  = $urandom_range(0, 10);
        sh_cfg[k] = $urandom_range(0, 7);
      end
      off_cfg = $urandom_range(0, 1023);
      thr_cfg = $urandom_range(0, 1023);
      apply_cfg();
      run_round($urandom_range(0, 1023), 1'b0, "rand");
    end

    // Overrun: a sample mid-round is dropped and the flag sticks.
    check("pre_overrun", overrun, 0);
    run_round($urandom_range(0, 1023), 1'b1, "ovr");
    check("overrun_set", overrun, 1);
    run_round($urandom_range(0, 1023), 1'b0, "after_ovr");
    check("overrun_sticky", overrun, 1);
    do_reset();
    check("overrun_cleared", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
